// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe referee: accepts one-hot moves from two players, judges legality,
// detects wins/draws on the mover's board and forfeits a turn on timeout.
module ttt_game_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mv_valid,
  input  logic [8:0] mv_pos,
  output logic       mv_ready,
  output logic [8:0] a_pos,
  output logic [8:0] b_pos,
  output logic       turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [7:0] win_line,
  output logic       illegal,
  output logic       timeout
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [2:0] {IDLE, WAIT_A, WAIT_B, CHECK, DONE} state_e;

  state_e           state_q, state_d;
  logic [8:0]       a_q, a_d, b_q, b_d;
  logic             turn_q, turn_d;
  logic             over_q, over_d;
  logic [1:0]       winner_q, winner_d;
  logic [7:0]       line_q, line_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;

  logic       handshake;
  logic       mv_legal;
  logic [7:0] hits;

  // Bit order of the result matches the win_line encoding.
  function automatic logic [7:0] line_hits(input logic [8:0] bd);
    logic [7:0] h;
    h[0] = &bd[8:6];
    h[1] = &bd[5:3];
    h[2] = &bd[2:0];
    h[3] = bd[8] & bd[5] & bd[2];
    h[4] = bd[7] & bd[4] & bd[1];
    h[5] = bd[6] & bd[3] & bd[0];
    h[6] = bd[8] & bd[4] & bd[0];
    h[7] = bd[2] & bd[4] & bd[6];
    return h;
  endfunction

  assign mv_ready  = ((state_q == WAIT_A) || (state_q == WAIT_B)) && !start;
  assign handshake = mv_valid && mv_ready;
  assign mv_legal  = (mv_pos != 9'd0) && ((mv_pos & (mv_pos - 9'd1)) == 9'd0)
                  && ((mv_pos & (a_q | b_q)) == 9'd0);
  // In CHECK, turn_q still names the player who just moved.
  assign hits      = line_hits(turn_q ? b_q : a_q);

  // NOTE: every next-state signal gets a default first, so this block can never infer a latch.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    turn_d    = turn_q;
    over_d    = over_q;
    winner_d  = winner_q;
    line_d    = line_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      WAIT_A, WAIT_B: begin
        if (handshake) begin
          cnt_d = '0;
          if (mv_legal) begin
            if (turn_q) b_d = b_q | mv_pos;
            else        a_d = a_q | mv_pos;
            state_d = CHECK;
          end else begin
            illegal_d = 1'b1;
          end
        end else if (TIMEOUT_CYC > 0) begin
          if (cnt_q == CNT_LAST) begin
            timeout_d = 1'b1;
            turn_d    = ~turn_q;
            state_d   = (state_q == WAIT_A) ? WAIT_B : WAIT_A;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      CHECK: begin
        // Win is judged before fullness so a ninth-move win is not a draw.
        if (|hits) begin
          line_d   = hits;
          winner_d = turn_q ? 2'b10 : 2'b01;
          over_d   = 1'b1;
          state_d  = DONE;
        end else if ((a_q | b_q) == 9'h1FF) begin
          line_d   = 8'h00;
          winner_d = 2'b11;
          over_d   = 1'b1;
          state_d  = DONE;
        end else begin
          turn_d  = ~turn_q;
          state_d = turn_q ? WAIT_A : WAIT_B;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase

    if (start) begin
      state_d   = WAIT_A;
      a_d       = 9'd0;
      b_d       = 9'd0;
      turn_d    = 1'b0;
      over_d    = 1'b0;
      winner_d  = 2'b00;
      line_d    = 8'h00;
      cnt_d     = '0;
      illegal_d = 1'b0;
      timeout_d = 1'b0;
    end
  end

  // NOTE: rst is sampled inside the clocked block (synchronous); all state uses non-blocking assignment.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= 9'd0;
      b_q       <= 9'd0;
      turn_q    <= 1'b0;
      over_q    <= 1'b0;
      winner_q  <= 2'b00;
      line_q    <= 8'h00;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      turn_q    <= turn_d;
      over_q    <= over_d;
      winner_q  <= winner_d;
      line_q    <= line_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign a_pos     = a_q;
  assign b_pos     = b_q;
  assign turn      = turn_q;
  assign game_over = over_q;
  assign winner    = winner_q;
  assign win_line  = line_q;
  assign illegal   = illegal_q;
  assign timeout   = timeout_q;

endmodule
